mem_bus_resp: RTL and testbench

Responder end of the byte-wide memory bus driven by `mem_ctrl`: one address, one read/write flag and one data byte per cycle. Decodes each access to either the on-chip byte RAM or the memory-mapped I/O window, and returns read data one cycle later. The I/O window connects to a host link through a transmit FIFO and a receive FIFO, and exposes a halt register for simulation and board tests.

---
 rtl/mem_bus_resp_pkg.sv | 36 +++
 rtl/mem_bus_resp_byte_fifo.sv | 61 ++++++
 rtl/mem_bus_resp.sv | 111 +++++++++++
 tb/tb_mem_bus_resp.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_resp_pkg.sv
// Shared constants, request struct and address decode for the memory bus responder.
package mem_bus_resp_pkg;

   localparam logic [1:0] IO_SEL      = 2'b11;
   localparam logic [2:0] IO_DATA_OFS = 3'h0;
   localparam logic [2:0] IO_STAT_OFS = 3'h4;

   typedef enum logic [1:0] {
      SEL_RAM,
      SEL_IO_DATA,
      SEL_IO_STAT,
      SEL_IO_NONE
   } sel_e;

   typedef struct packed {
      logic [31:0] addr;
      logic        r_nw;
      logic [7:0]  data;
   } mem_req_t;

   // Only bits 17:16 pick the window; inside I/O only the low three bits matter.
   function automatic sel_e decode(input logic [31:0] addr);
      sel_e sel;
      if (addr[17:16] != IO_SEL) begin
         sel = SEL_RAM;
      end else begin
         case (addr[2:0])
            IO_DATA_OFS: sel = SEL_IO_DATA;
            IO_STAT_OFS: sel = SEL_IO_STAT;
            default:     sel = SEL_IO_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/mem_bus_resp_byte_fifo.sv
// Byte FIFO with simultaneous push/pop; empty/full are registered from the next count.
module byte_fifo #(
   parameter int FIFO_AW = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [7:0]         din,
   output logic [7:0]         dout,
   output logic [FIFO_AW:0]   count,
   output logic               empty,
   output logic               full
);

   localparam int              DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count_nxt;
   logic               do_push;
   logic               do_pop;

   // A full FIFO drops the push even if a pop frees a slot in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      count_nxt = count;
      case ({do_push, do_pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == CNT_FULL);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/mem_bus_resp.sv
// Byte-wide bus responder: on-chip RAM plus an I/O window with host TX/RX FIFOs and halt flag.
module mem_bus_resp
   import mem_bus_resp_pkg::*;
#(
   parameter int RAM_AW  = 17,
   parameter int FIFO_AW = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [31:0] addr_in,
   input  logic        r_nw_in,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        io_full,
   output logic        tx_ovf,
   output logic        halted
);

   localparam int               DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] TX_HI = (FIFO_AW+1)'(DEPTH - 1);

   mem_req_t           req;
   sel_e               sel;
   logic [RAM_AW-1:0]  ram_a;
   logic [7:0]         ram [2**RAM_AW];

   logic               tx_push, tx_pop, rx_push, rx_pop;
   logic [7:0]         rx_dout;
   logic [FIFO_AW:0]   tx_count, rx_count;
   logic               tx_empty, tx_full, rx_empty, rx_full;
   logic [7:0]         stat;
   logic               unused_bits;

   assign req   = '{addr: addr_in, r_nw: r_nw_in, data: data_in};
   assign sel   = decode(req.addr);
   assign ram_a = req.addr[RAM_AW-1:0];

   assign unused_bits = ^{req.addr[31:18], rx_count[FIFO_AW]};

   // Everything that changes state is qualified by rdy, host side included.
   assign tx_push = rdy && req.r_nw  && (sel == SEL_IO_DATA);
   assign rx_pop  = rdy && !req.r_nw && (sel == SEL_IO_DATA);
   assign tx_pop  = rdy && tx_valid && tx_ready;
   assign rx_push = rdy && rx_valid && rx_ready;

   byte_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (req.data),
      .dout  (tx_data),
      .count (tx_count),
      .empty (tx_empty),
      .full  (tx_full)
   );

   byte_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (rx_data),
      .dout  (rx_dout),
      .count (rx_count),
      .empty (rx_empty),
      .full  (rx_full)
   );

   assign tx_valid = !tx_empty;
   assign rx_ready = !rx_full;
   assign io_full  = (tx_count >= TX_HI);

   // A full RX FIFO wraps its low count bits to 0; rx_empty disambiguates.
   assign stat = {3'b000, rx_empty, tx_full, rx_count[2:0]};

   always_ff @(posedge clk) begin
      if (rdy && req.r_nw && (sel == SEL_RAM)) ram[ram_a] <= req.data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= 8'h00;
      end else if (rdy && !req.r_nw) begin
         case (sel)
            SEL_RAM:     data_out <= ram[ram_a];
            SEL_IO_DATA: data_out <= rx_empty ? 8'h00 : rx_dout;
            SEL_IO_STAT: data_out <= stat;
            default:     data_out <= 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_ovf <= 1'b0;
         halted <= 1'b0;
      end else if (rdy && req.r_nw) begin
         if (sel == SEL_IO_DATA && tx_full) tx_ovf <= 1'b1;
         if (sel == SEL_IO_STAT)            halted <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_bus_resp.sv
// Directed bench for mem_bus_resp with a queue-based reference model checked every cycle.
module tb_mem_bus_resp;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic [31:0] addr;
   logic        r_nw;
   logic [7:0]  wdata;
   logic [7:0]  data_out, tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, rx_ready, io_full, tx_ovf, halted;

   int n_cmp = 0;
   int n_bad = 0;

   mem_bus_resp dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .addr_in  (addr),
      .r_nw_in  (r_nw),
      .data_in  (wdata),
      .data_out (data_out),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .io_full  (io_full),
      .tx_ovf   (tx_ovf),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h want %02h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: byte memory, two queues, two sticky bits.
   logic [7:0] m_ram [int];
   logic [7:0] m_txq [$];
   logic [7:0] m_rxq [$];
   logic [7:0] m_dout;
   bit         m_dv, m_ovf, m_halt, live;
   bit         m_io, m_txpush, m_txpop, m_rxpush, m_rxpop;
   int         m_ntx, m_nrx, m_ra;
   logic [2:0] m_ofs;

   always @(posedge clk) begin
      live = 1'b1;
      if (rst) begin
         m_txq.delete();
         m_rxq.delete();
         m_dout = 8'h00;
         m_dv   = 1'b1;
         m_ovf  = 1'b0;
         m_halt = 1'b0;
      end else if (rdy) begin
         m_io  = (addr[17:16] == 2'b11);
         m_ofs = addr[2:0];
         m_ra  = int'(addr[16:0]);
         m_ntx = m_txq.size();
         m_nrx = m_rxq.size();
         m_txpush = 1'b0;
         m_rxpop  = 1'b0;
         m_txpop  = (m_ntx > 0) && tx_ready;
         m_rxpush = rx_valid && (m_nrx < 8);
         if (!r_nw) begin
            m_dv = 1'b1;
            if (!m_io) begin
               if (m_ram.exists(m_ra)) m_dout = m_ram[m_ra];
               else m_dv = 1'b0;
            end else if (m_ofs == 3'h0) begin
               m_dout  = (m_nrx > 0) ? m_rxq[0] : 8'h00;
               m_rxpop = (m_nrx > 0);
            end else if (m_ofs == 3'h4) begin
               m_dout = {3'b000, m_nrx == 0, m_ntx == 8, 3'(m_nrx)};
            end else begin
               m_dout = 8'h00;
            end
         end else begin
            if (!m_io) m_ram[m_ra] = wdata;
            else if (m_ofs == 3'h0) begin
               if (m_ntx == 8) m_ovf = 1'b1;
               else m_txpush = 1'b1;
            end else if (m_ofs == 3'h4) m_halt = 1'b1;
         end
         if (m_txpop)  void'(m_txq.pop_front());
         if (m_txpush) m_txq.push_back(wdata);
         if (m_rxpop)  void'(m_rxq.pop_front());
         if (m_rxpush) m_rxq.push_back(rx_data);
      end
   end

   always @(negedge clk) begin
      if (live) begin
         if (m_dv) chk("cyc_data_out", data_out, m_dout);
         chk("cyc_tx_valid", {7'b0, tx_valid}, {7'b0, m_txq.size() != 0});
         if (m_txq.size() != 0) chk("cyc_tx_data", tx_data, m_txq[0]);
         chk("cyc_rx_ready", {7'b0, rx_ready}, {7'b0, m_rxq.size() != 8});
         chk("cyc_io_full",  {7'b0, io_full},  {7'b0, m_txq.size() >= 7});
         chk("cyc_tx_ovf",   {7'b0, tx_ovf},   {7'b0, m_ovf});
         chk("cyc_halted",   {7'b0, halted},   {7'b0, m_halt});
      end
   end

   task automatic idle();
      addr = 32'h0; r_nw = 1'b0; wdata = 8'h00;
   endtask

   // Present one access, let the edge take it, land 1 time unit after the edge.
   task automatic acc(input logic [31:0] a, input logic rw, input logic [7:0] d);
      addr = a; r_nw = rw; wdata = d;
      @(posedge clk); #1;
      idle();
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      idle();
      step(); step();
      chk("rst_data_out", data_out, 8'h00);
      chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
      chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
      chk("rst_io_full",  {7'b0, io_full},  8'h00);
      chk("rst_tx_ovf",   {7'b0, tx_ovf},   8'h00);
      chk("rst_halted",   {7'b0, halted},   8'h00);
      rst = 1'b0;
      step();

      // RAM round trip
      acc(32'h100, 1'b1, 8'hEF); acc(32'h101, 1'b1, 8'hBE);
      acc(32'h102, 1'b1, 8'hAD); acc(32'h103, 1'b1, 8'hDE);
      acc(32'h100, 1'b0, 8'h00); chk("ram_rd0", data_out, 8'hEF);
      acc(32'h101, 1'b0, 8'h00); chk("ram_rd1", data_out, 8'hBE);
      acc(32'h102, 1'b0, 8'h00); chk("ram_rd2", data_out, 8'hAD);
      acc(32'h103, 1'b0, 8'h00); chk("ram_rd3", data_out, 8'hDE);

      // Transmit path
      acc(32'h30000, 1'b1, 8'h41); acc(32'h30000, 1'b1, 8'h42);
      chk("tx_head0", tx_data, 8'h41);
      chk("tx_valid1", {7'b0, tx_valid}, 8'h01);
      tx_ready = 1'b1;
      step(); chk("tx_head1", tx_data, 8'h42);
      step(); chk("tx_drained", {7'b0, tx_valid}, 8'h00);
      tx_ready = 1'b0;

      // Transmit overflow
      for (int i = 0; i < 9; i++) begin
         acc(32'h30000, 1'b1, 8'(8'h50 + i));
         if (i == 5) chk("io_full_6", {7'b0, io_full}, 8'h00);
         if (i == 6) chk("io_full_7", {7'b0, io_full}, 8'h01);
         if (i == 7) chk("tx_ovf_8",  {7'b0, tx_ovf},  8'h00);
         if (i == 8) chk("tx_ovf_9",  {7'b0, tx_ovf},  8'h01);
      end
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("tx_ovf_drain", tx_data, 8'(8'h50 + i));
         step();
      end
      tx_ready = 1'b0;
      chk("tx_ovf_empty", {7'b0, tx_valid}, 8'h00);

      // Receive path
      rx_valid = 1'b1; rx_data = 8'h31; step();
      rx_data = 8'h32; step();
      rx_valid = 1'b0;
      acc(32'h30004, 1'b0, 8'h00); chk("rx_stat", data_out, 8'h02);
      acc(32'h30000, 1'b0, 8'h00); chk("rx_pop0", data_out, 8'h31);
      acc(32'h30000, 1'b0, 8'h00); chk("rx_pop1", data_out, 8'h32);
      acc(32'h30000, 1'b0, 8'h00); chk("rx_pop_empty", data_out, 8'h00);

      // Full receive FIFO with simultaneous host push and core pop
      rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rx_data = 8'(8'h60 + i); step();
      end
      rx_valid = 1'b0;
      chk("rx_full_ready", {7'b0, rx_ready}, 8'h00);
      acc(32'h30004, 1'b0, 8'h00); chk("rx_full_stat", data_out, 8'h00);
      addr = 32'h30000; r_nw = 1'b0; rx_valid = 1'b1; rx_data = 8'hAA;
      chk("rx_sim_ready", {7'b0, rx_ready}, 8'h00);
      step();
      rx_valid = 1'b0; idle();
      chk("rx_sim_pop", data_out, 8'h60);
      chk("rx_sim_ready_back", {7'b0, rx_ready}, 8'h01);
      acc(32'h30004, 1'b0, 8'h00); chk("rx_stat7", data_out, 8'h07);
      for (int i = 1; i < 8; i++) begin
         acc(32'h30000, 1'b0, 8'h00); chk("rx_drain", data_out, 8'(8'h60 + i));
      end
      acc(32'h30000, 1'b0, 8'h00); chk("rx_drain_end", data_out, 8'h00);

      // Unmapped offsets, aliasing of high address bits, rdy gating
      acc(32'h30001, 1'b1, 8'h99);
      acc(32'h30002, 1'b0, 8'h00); chk("io_unmapped", data_out, 8'h00);
      acc(32'h400100, 1'b0, 8'h00); chk("ram_alias", data_out, 8'hEF);
      rdy = 1'b0; addr = 32'h101; r_nw = 1'b0;
      step(); chk("rdy_hold", data_out, 8'hEF);
      addr = 32'h100; r_nw = 1'b1; wdata = 8'h55; step();
      addr = 32'h30000; r_nw = 1'b1; wdata = 8'h66; step();
      rdy = 1'b1; idle();
      chk("rdy_no_push", {7'b0, tx_valid}, 8'h00);
      acc(32'h100, 1'b0, 8'h00); chk("rdy_no_write", data_out, 8'hEF);

      // Halt and reset
      acc(32'h30000, 1'b1, 8'h77);
      acc(32'h30004, 1'b1, 8'h00); chk("halted_set", {7'b0, halted}, 8'h01);
      rst = 1'b1; step(); rst = 1'b0;
      chk("rst2_halted",   {7'b0, halted},   8'h00);
      chk("rst2_tx_valid", {7'b0, tx_valid}, 8'h00);
      chk("rst2_tx_ovf",   {7'b0, tx_ovf},   8'h00);
      chk("rst2_rx_ready", {7'b0, rx_ready}, 8'h01);
      acc(32'h100, 1'b0, 8'h00); chk("rst2_ram_keep", data_out, 8'hEF);
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
